ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester, round-robin access controller for the single-port 16x4 RAM. Each requester presents a read or write with a valid/ready handshake. The block serialises the requests onto the RAM's `we`/`addr`/`d` inputs and captures `q` (the signal the RAM output interface monitors). It returns read data, or a write acknowledge, to the requester that was granted.

## Interface
Parameters:
- `ADDR_W`, 4: RAM address width.
- `DATA_W`, 4: RAM data width; must match RAM `q`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req0_valid` input 1: requester 0 has a request pending.
- `req0_ready` output 1: requester 0 request accepted this cycle.
- `req0_we` input 1: 1 = write, 0 = read.
- `req0_addr` input ADDR_W: request address.
- `req0_wdata` input DATA_W: write data; ignored for reads.
- `rsp0_valid` output 1: one-cycle pulse, response for requester 0.
- `rsp0_rdata` output DATA_W: read data; 0 for write acks.
- `req1_*`, `rsp1_*`: identical set for requester 1.
- `ram_we` output 1: RAM write enable.
- `ram_addr` output ADDR_W: RAM address.
- `ram_d` output DATA_W: RAM write data.
- `ram_q` input DATA_W: RAM read data, valid the cycle after the address is sampled (synchronous read).

## Operation
- FSM states:
  - IDLE: wait for a request.
  - ACCESS: drive the RAM for one cycle.
  - CAPTURE: reads only; `ram_q` is valid this cycle.
- IDLE:
  - If any `reqN_valid` is high, grant one requester and assert its `reqN_ready` combinationally (at most one ready high).
  - Latch the winner's id, `we`, `addr` and `wdata` into `ram_addr`/`ram_d` registers, then go to ACCESS.
- Grant rule:
  - If only one requester is valid, it wins.
  - If both are valid, the one named by priority pointer `prio` wins.
  - `prio` moves to the non-granted requester on every grant.
- ACCESS:
  - `ram_we` = latched `we`; it is high only in ACCESS.
  - Write: go to IDLE and register `rspN_valid`=1, `rspN_rdata`=0 for the granted id.
  - Read: go to CAPTURE.
- CAPTURE: register `rspN_rdata` = `ram_q` and `rspN_valid`=1 for the granted id, then go to IDLE.
- `ready` is never high outside IDLE.
- Requesters hold valid and their fields stable until ready; withdrawing valid before ready is legal (no grant occurs).
- The non-granted `rsp` outputs stay 0 valid and hold their previous rdata.

## Timing
- Reset values:
  - FSM in IDLE.
  - `prio`=0.
  - `ram_we`=0, `ram_addr`=0, `ram_d`=0.
  - `rsp0/1_valid`=0, `rsp0/1_rdata`=0.
  - `req0/1_ready`=0 (also 0 while `rst_n` is low).
- Write, handshake in cycle T: `ram_we`=1 in T+1; `rsp_valid` in T+2; next accept possible in T+2.
- Read, handshake in cycle T: address on RAM in T+1; `ram_q` sampled in T+2; `rsp_valid` + data in T+3; next accept possible in T+3.
- Peak throughput: one write per 2 cycles, one read per 3 cycles.
- A response pulse and a new ready may coincide in the same IDLE cycle.
- Reset mid-transaction: the transaction is abandoned, no response is issued, and a write in ACCESS is cut off asynchronously (`ram_we` forced to 0).

## Structure
- Package `ram_ctrl_pkg`:
  - `state_t` enum (IDLE, ACCESS, CAPTURE).
  - Default `ADDR_W`/`DATA_W` constants.
  - `req_id_t` (1 bit).
- Sub-module `rr_arbiter2`:
  - Inputs: `clk`, `rst_n`, two valids, an advance strobe.
  - Outputs: one-hot grant and `prio`.
  - `ram_arbiter` instantiates it and provides the FSM, the latches and the response registers.
- The top-level connects `ram_q` to the same net the RAM output interface monitors.

## Test plan
- Reset: hold `rst_n`=0 with both valids high -> all outputs 0, no ready. Release -> requester 0 readied first (`prio`=0).
- Single write then read: req0 writes addr 5, data 0xA -> `ram_we`=1 at T+1, `rsp0_valid` at T+2 with rdata 0. Req0 then reads addr 5 -> `rsp0_valid` at T+3 with rdata 0xA.
- Contention: both requesters hold reads (addr 1 and addr 2) back-to-back for 4 grants -> grants alternate 0,1,0,1; each `rsp` carries its own address's data; `rsp1` never pulses for a req0 grant.
- Fairness after a single requester: req1 alone for 3 grants, then both valid -> req0 wins next.
- Reset during ACCESS of a write to addr 7 (old value 0x3) -> no `rsp` pulse, FSM in IDLE; a later read of addr 7 returns 0x3.
- Valid withdrawn while busy: req1 raises valid during req0's CAPTURE and drops it before IDLE -> no grant, no response for req1.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the two-requester RAM access controller.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered priority pointer.
module rr_arbiter2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       adv_i,
  output logic [1:0] gnt_c_o,
  output req_id_t    prio_o
);

  req_id_t prio_q, prio_d;

  always_comb begin
    gnt_c_o = 2'b00;
    if (valid0_i && valid1_i) begin
      gnt_c_o = prio_q ? 2'b10 : 2'b01;
    end else begin
      gnt_c_o = {valid1_i, valid0_i};
    end
  end

  // Pointer moves to whichever requester lost (or was absent) on every grant.
  always_comb begin
    prio_d = prio_q;
    if (adv_i && (gnt_c_o != 2'b00)) begin
      prio_d = req_id_t'(~gnt_c_o[1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign prio_o = prio_q;

endmodule

// File: rtl/ram_arbiter.sv
// Serialises two valid/ready requesters onto a single-port synchronous RAM and
// returns read data or a write acknowledge to the granted requester.
module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_q
);

  state_t              state_q, state_d;
  req_id_t             id_q, id_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_d_q, ram_d_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0]   rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_W-1:0]   rsp1_rdata_q, rsp1_rdata_d;

  logic [1:0]          gnt_c;
  req_id_t             prio;
  logic                adv_c;
  logic                rsp_fire_c;
  logic [DATA_W-1:0]   rsp_data_c;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .adv_i    (adv_c),
    .gnt_c_o  (gnt_c),
    .prio_o   (prio)
  );

  // FSM next state; the RAM command is latched at the IDLE handshake.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_d_d    = ram_d_q;
    adv_c      = 1'b0;
    rsp_fire_c = 1'b0;
    rsp_data_c = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_c != 2'b00) begin
          adv_c   = 1'b1;
          id_d    = (req0_valid && req1_valid) ? prio : req_id_t'(req1_valid);
          state_d = ACCESS;
          if (gnt_c[1]) begin
            ram_we_d   = req1_we;
            ram_addr_d = req1_addr;
            ram_d_d    = req1_wdata;
          end else begin
            ram_we_d   = req0_we;
            ram_addr_d = req0_addr;
            ram_d_d    = req0_wdata;
          end
        end
      end
      ACCESS: begin
        if (ram_we_q) begin
          rsp_fire_c = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d    = CAPTURE;
        end
      end
      CAPTURE: begin
        rsp_fire_c = 1'b1;
        rsp_data_c = ram_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the granted requester's response registers update; the other holds rdata.
  always_comb begin
    rsp0_valid_d = rsp_fire_c && (id_q == 1'b0);
    rsp1_valid_d = rsp_fire_c && (id_q == 1'b1);
    rsp0_rdata_d = rsp0_valid_d ? rsp_data_c : rsp0_rdata_q;
    rsp1_rdata_d = rsp1_valid_d ? rsp_data_c : rsp1_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      id_q         <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_d_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_d_q      <= ram_d_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  // Ready is the one combinational output; it is masked while reset is held.
  assign req0_ready = rst_n && (state_q == IDLE) && gnt_c[0];
  assign req1_ready = rst_n && (state_q == IDLE) && gnt_c[1];

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_d      = ram_d_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed table, hand-written corner sequences, and random
// traffic checked every cycle against a transaction-level reference model.
module tb_ram_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;
  logic          req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_q;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // 16x4 synchronous single-port RAM, contents survive reset; mem[i] starts at i.
  logic [DW-1:0] mem [16];
  logic          mem_ok = 1'b0;
  always @(posedge clk) begin
    if (!mem_ok) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'(i);
      mem_ok <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_d;
    end
    ram_q <= mem[ram_addr];
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state: a shadow memory plus the one outstanding transaction.
  int            cyc = 0;
  int            busy = 0;
  logic          mprio = 1'b0;
  logic          pend_act = 1'b0, pend_id = 1'b0;
  int            pend_due = 0;
  logic [3:0]    pend_data = '0;
  logic          acc_act = 1'b0, acc_we = 1'b0;
  int            acc_cyc = 0;
  logic [3:0]    acc_addr = '0, acc_d = '0;
  logic [3:0]    exp_rd0 = '0, exp_rd1 = '0;
  logic [3:0]    shadow [16];

  logic          s_rdy0, s_rdy1, s_rv0, s_rv1;
  logic [3:0]    s_rd0, s_rd1;

  task automatic model_cycle();
    logic e0, e1, er0, er1, ewe, id, we;
    logic [3:0] a, d;
    cyc++;
    if (!rst_n) begin
      chk("rst_ready0", int'(req0_ready), 0);
      chk("rst_ready1", int'(req1_ready), 0);
      chk("rst_rsp0_valid", int'(rsp0_valid), 0);
      chk("rst_rsp1_valid", int'(rsp1_valid), 0);
      chk("rst_rsp0_rdata", int'(rsp0_rdata), 0);
      chk("rst_rsp1_rdata", int'(rsp1_rdata), 0);
      chk("rst_ram_we", int'(ram_we), 0);
      chk("rst_ram_addr", int'(ram_addr), 0);
      chk("rst_ram_d", int'(ram_d), 0);
      busy = 0; mprio = 1'b0; pend_act = 1'b0; acc_act = 1'b0;
      exp_rd0 = '0; exp_rd1 = '0;
    end else begin
      e0 = 1'b0; e1 = 1'b0;
      if (busy == 0) begin
        if (req0_valid && req1_valid) begin
          e0 = !mprio; e1 = mprio;
        end else begin
          e0 = req0_valid; e1 = req1_valid;
        end
      end
      chk("mon_ready0", int'(req0_ready), int'(e0));
      chk("mon_ready1", int'(req1_ready), int'(e1));
      er0 = pend_act && (pend_due == cyc) && !pend_id;
      er1 = pend_act && (pend_due == cyc) && pend_id;
      if (er0) exp_rd0 = pend_data;
      if (er1) exp_rd1 = pend_data;
      if (pend_act && (pend_due == cyc)) pend_act = 1'b0;
      chk("mon_rsp0_valid", int'(rsp0_valid), int'(er0));
      chk("mon_rsp1_valid", int'(rsp1_valid), int'(er1));
      chk("mon_rsp0_rdata", int'(rsp0_rdata), int'(exp_rd0));
      chk("mon_rsp1_rdata", int'(rsp1_rdata), int'(exp_rd1));
      ewe = acc_act && (acc_cyc == cyc) && acc_we;
      chk("mon_ram_we", int'(ram_we), int'(ewe));
      if (acc_act && (acc_cyc == cyc)) begin
        chk("mon_ram_addr", int'(ram_addr), int'(acc_addr));
        if (acc_we) begin
          chk("mon_ram_d", int'(ram_d), int'(acc_d));
          shadow[acc_addr] = acc_d;
        end
        acc_act = 1'b0;
      end
      if (busy > 0) busy--;
      if (e0 || e1) begin
        id = e1;
        we = id ? req1_we : req0_we;
        a  = id ? req1_addr : req0_addr;
        d  = id ? req1_wdata : req0_wdata;
        busy      = we ? 1 : 2;
        acc_act   = 1'b1; acc_cyc = cyc + 1; acc_we = we; acc_addr = a; acc_d = d;
        pend_act  = 1'b1; pend_id = id; pend_due = cyc + (we ? 2 : 3);
        pend_data = we ? 4'd0 : shadow[a];
        mprio     = !id;
      end
    end
  endtask

  // Sample and model-check at the falling edge, then land just after the next rising edge.
  task automatic clk_step();
    @(negedge clk);
    s_rdy0 = req0_ready; s_rdy1 = req1_ready;
    s_rv0  = rsp0_valid; s_rv1  = rsp1_valid;
    s_rd0  = rsp0_rdata; s_rd1  = rsp1_rdata;
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       v0, v1, we0, we1;
    logic [3:0] a0, a1, d0, d1;
    logic       win;
    logic [3:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic v0, input logic v1,
                              input logic we0, input logic [3:0] a0, input logic [3:0] d0,
                              input logic we1, input logic [3:0] a1, input logic [3:0] d1,
                              input logic win, input logic [3:0] rd);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.we0 = we0; v.we1 = we1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.win = win; v.rd = rd;
    return v;
  endfunction

  task automatic run_op(input vec_t v, input int idx, output int wait_n);
    int lat;
    logic win, wwe;
    req0_valid = v.v0; req0_we = v.we0; req0_addr = v.a0; req0_wdata = v.d0;
    req1_valid = v.v1; req1_we = v.we1; req1_addr = v.a1; req1_wdata = v.d1;
    wait_n = 0;
    do begin clk_step(); wait_n++; end while (!(s_rdy0 || s_rdy1) && wait_n < 20);
    chk($sformatf("op%0d_granted", idx), int'(s_rdy0 || s_rdy1), 1);
    chk($sformatf("op%0d_one_ready", idx), int'(s_rdy0 && s_rdy1), 0);
    win = s_rdy1;
    chk($sformatf("op%0d_winner", idx), int'(win), int'(v.win));
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (!(s_rdy0 || s_rdy1)) return;
    wwe = v.win ? v.we1 : v.we0;
    lat = 0;
    do begin clk_step(); lat++; end while (!(s_rv0 || s_rv1) && lat < 8);
    chk($sformatf("op%0d_latency", idx), lat, wwe ? 2 : 3);
    chk($sformatf("op%0d_rsp_win", idx), int'(v.win ? s_rv1 : s_rv0), 1);
    chk($sformatf("op%0d_rsp_other", idx), int'(v.win ? s_rv0 : s_rv1), 0);
    chk($sformatf("op%0d_rdata", idx), int'(v.win ? s_rd1 : s_rd0), int'(v.rd));
  endtask

  vec_t tbl [13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, cnt_r1, cnt_r0, seen_rd;
    for (int i = 0; i < 16; i++) shadow[i] = 4'(i);
    tbl[0]  = mk(1, 1, 0, 4'h1, 4'h0, 0, 4'h2, 4'h0, 0, 4'h1);
    tbl[1]  = mk(1, 0, 1, 4'h5, 4'hA, 0, 4'h0, 4'h0, 0, 4'h0);
    tbl[2]  = mk(1, 0, 0, 4'h5, 4'h0, 0, 4'h0, 4'h0, 0, 4'hA);
    tbl[3]  = mk(0, 1, 0, 4'h0, 4'h0, 1, 4'h2, 4'h9, 1, 4'h0);
    tbl[4]  = mk(1, 1, 0, 4'h1, 4'h0, 0, 4'h2, 4'h0, 0, 4'h1);
    tbl[5]  = mk(1, 1, 0, 4'h1, 4'h0, 0, 4'h2, 4'h0, 1, 4'h9);
    tbl[6]  = mk(1, 1, 0, 4'h1, 4'h0, 0, 4'h2, 4'h0, 0, 4'h1);
    tbl[7]  = mk(1, 1, 0, 4'h1, 4'h0, 0, 4'h2, 4'h0, 1, 4'h9);
    tbl[8]  = mk(0, 1, 0, 4'h0, 4'h0, 0, 4'h3, 4'h0, 1, 4'h3);
    tbl[9]  = mk(0, 1, 0, 4'h0, 4'h0, 1, 4'h4, 4'hC, 1, 4'h0);
    tbl[10] = mk(0, 1, 0, 4'h0, 4'h0, 0, 4'h4, 4'h0, 1, 4'hC);
    tbl[11] = mk(1, 1, 0, 4'h5, 4'h0, 0, 4'h6, 4'h0, 0, 4'hA);
    tbl[12] = mk(1, 0, 1, 4'h7, 4'h3, 0, 4'h0, 4'h0, 0, 4'h0);

    // Reset held with both requesters valid; requester 0 must win right after release.
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 4'h1; req0_wdata = 4'h0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 4'h2; req1_wdata = 4'h0;
    repeat (3) clk_step();
    rst_n = 1'b1;
    run_op(tbl[0], 0, w);
    chk("reset_first_grant_wait", w, 1);
    for (int i = 1; i < 13; i++) run_op(tbl[i], i, w);

    // Reset during the ACCESS cycle of a write: no write, no response.
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 4'h7; req0_wdata = 4'hE;
    w = 0;
    do begin clk_step(); w++; end while (!s_rdy0 && w < 20);
    chk("abort_granted", int'(s_rdy0), 1);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_ram_we_cut", int'(ram_we), 0);
    cnt_r0 = 0;
    repeat (2) begin clk_step(); cnt_r0 += int'(s_rv0 || s_rv1); end
    rst_n = 1'b1;
    repeat (3) begin clk_step(); cnt_r0 += int'(s_rv0 || s_rv1); end
    chk("abort_no_rsp", cnt_r0, 0);
    run_op(mk(1, 0, 0, 4'h7, 4'h0, 0, 4'h0, 4'h0, 0, 4'h3), 13, w);
    chk("abort_idle_after_reset", w, 1);

    // Requester 1 raises valid during requester 0's CAPTURE and withdraws before IDLE.
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 4'h3;
    w = 0;
    do begin clk_step(); w++; end while (!s_rdy0 && w < 20);
    chk("wd_granted0", int'(s_rdy0), 1);
    req0_valid = 1'b0;
    clk_step();
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 4'h9;
    clk_step();
    chk("wd_no_ready1_capture", int'(s_rdy1), 0);
    req1_valid = 1'b0;
    cnt_r1 = 0; cnt_r0 = 0; seen_rd = -1;
    repeat (5) begin
      clk_step();
      cnt_r1 += int'(s_rv1) + int'(s_rdy1);
      if (s_rv0) begin cnt_r0++; seen_rd = int'(s_rd0); end
    end
    chk("wd_no_req1_activity", cnt_r1, 0);
    chk("wd_rsp0_count", cnt_r0, 1);
    chk("wd_rsp0_data", seen_rd, 3);

    // Random traffic with occasional withdrawals and resets.
    for (int n = 0; n < 2500; n++) begin
      if (s_rdy0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_we    = 1'($urandom_range(0, 1));
        req0_addr  = 4'($urandom_range(0, 15));
        req0_wdata = 4'($urandom_range(0, 15));
      end else if ($urandom_range(0, 15) == 0) begin
        req0_valid = 1'b0;
      end
      if (s_rdy1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_we    = 1'($urandom_range(0, 1));
        req1_addr  = 4'($urandom_range(0, 15));
        req1_wdata = 4'($urandom_range(0, 15));
      end else if ($urandom_range(0, 15) == 0) begin
        req1_valid = 1'b0;
      end
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        repeat (2) clk_step();
        rst_n = 1'b1;
      end
      clk_step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (5) clk_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
